// File: rtl/management_bus_arbiter.sv
// Round-robin arbiter sharing the core management bus between the JTAG debug
// port and the Wishbone slave port, with downstream wait states and a timeout.
module management_bus_arbiter #(
  parameter int ADDRESS_WIDTH  = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     jtag_enable,
  input  logic                     jtag_writeEnable,
  input  logic [3:0]               jtag_byteSelect,
  input  logic [ADDRESS_WIDTH-1:0] jtag_address,
  input  logic [DATA_WIDTH-1:0]    jtag_writeData,
  output logic [DATA_WIDTH-1:0]    jtag_readData,
  output logic                     jtag_ack,
  output logic                     jtag_error,

  input  logic                     wb_enable,
  input  logic                     wb_writeEnable,
  input  logic [3:0]               wb_byteSelect,
  input  logic [ADDRESS_WIDTH-1:0] wb_address,
  input  logic [DATA_WIDTH-1:0]    wb_writeData,
  output logic [DATA_WIDTH-1:0]    wb_readData,
  output logic                     wb_ack,
  output logic                     wb_error,
  output logic                     wb_busy,

  output logic                     bus_enable,
  output logic                     bus_writeEnable,
  output logic [3:0]               bus_byteSelect,
  output logic [ADDRESS_WIDTH-1:0] bus_address,
  output logic [DATA_WIDTH-1:0]    bus_writeData,
  input  logic [DATA_WIDTH-1:0]    bus_readData,
  input  logic                     bus_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;
  typedef enum logic {G_JTAG = 1'b0, G_WB = 1'b1} grant_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  grant_t                   r_grant;
  grant_t                   r_last_grant;
  grant_t                   w_pick;
  logic [7:0]               r_count;

  logic                     r_bus_enable;
  logic                     r_bus_writeEnable;
  logic [3:0]               r_bus_byteSelect;
  logic [ADDRESS_WIDTH-1:0] r_bus_address;
  logic [DATA_WIDTH-1:0]    r_bus_writeData;

  logic [DATA_WIDTH-1:0]    r_jtag_readData;
  logic                     r_jtag_ack;
  logic                     r_jtag_error;
  logic [DATA_WIDTH-1:0]    r_wb_readData;
  logic                     r_wb_ack;
  logic                     r_wb_error;

  logic                     w_any_request;
  logic                     w_granted_enable;
  logic                     w_timeout;
  logic                     w_complete;
  logic [DATA_WIDTH-1:0]    w_resp_data;

  assign w_any_request    = jtag_enable | wb_enable;
  assign w_granted_enable = (r_grant == G_JTAG) ? jtag_enable : wb_enable;
  assign w_timeout        = (r_count == TIMEOUT_LAST);
  // An abort (granted enable dropped) takes precedence over completion.
  assign w_complete       = w_granted_enable & (bus_ready | w_timeout);
  assign w_resp_data      = !bus_ready        ? '1 :
                            r_bus_writeEnable ? '0 : bus_readData;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_pick = G_WB;
    if (jtag_enable && wb_enable) begin
      w_pick = (r_last_grant == G_WB) ? G_JTAG : G_WB;
    end else if (jtag_enable) begin
      w_pick = G_JTAG;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_request) w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (!w_granted_enable) w_state_next = S_IDLE;
        else if (w_complete)   w_state_next = S_RESPOND;
      end
      S_RESPOND: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant           <= G_WB;
      r_last_grant      <= G_WB;
      r_count           <= '0;
      r_bus_enable      <= 1'b0;
      r_bus_writeEnable <= 1'b0;
      r_bus_byteSelect  <= '0;
      r_bus_address     <= '0;
      r_bus_writeData   <= '0;
      r_jtag_readData   <= '0;
      r_jtag_ack        <= 1'b0;
      r_jtag_error      <= 1'b0;
      r_wb_readData     <= '0;
      r_wb_ack          <= 1'b0;
      r_wb_error        <= 1'b0;
    end else begin
      // Response outputs live for the single RESPOND cycle only.
      r_jtag_readData <= '0;
      r_jtag_ack      <= 1'b0;
      r_jtag_error    <= 1'b0;
      r_wb_readData   <= '0;
      r_wb_ack        <= 1'b0;
      r_wb_error      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_request) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_count      <= '0;
            r_bus_enable <= 1'b1;
            if (w_pick == G_JTAG) begin
              r_bus_writeEnable <= jtag_writeEnable;
              r_bus_byteSelect  <= jtag_byteSelect;
              r_bus_address     <= jtag_address;
              r_bus_writeData   <= jtag_writeData;
            end else begin
              r_bus_writeEnable <= wb_writeEnable;
              r_bus_byteSelect  <= wb_byteSelect;
              r_bus_address     <= wb_address;
              r_bus_writeData   <= wb_writeData;
            end
          end
        end
        S_ACCESS: begin
          r_count <= r_count + 8'd1;
          if (!w_granted_enable || w_complete) begin
            r_bus_enable      <= 1'b0;
            r_bus_writeEnable <= 1'b0;
            r_bus_byteSelect  <= '0;
            r_bus_address     <= '0;
            r_bus_writeData   <= '0;
          end
          if (w_complete) begin
            if (r_grant == G_JTAG) begin
              r_jtag_ack      <= 1'b1;
              r_jtag_error    <= ~bus_ready;
              r_jtag_readData <= w_resp_data;
            end else begin
              r_wb_ack        <= 1'b1;
              r_wb_error      <= ~bus_ready;
              r_wb_readData   <= w_resp_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_busy         = wb_enable & (r_state != S_IDLE) & (r_grant == G_JTAG);

  assign bus_enable      = r_bus_enable;
  assign bus_writeEnable = r_bus_writeEnable;
  assign bus_byteSelect  = r_bus_byteSelect;
  assign bus_address     = r_bus_address;
  assign bus_writeData   = r_bus_writeData;

  assign jtag_readData   = r_jtag_readData;
  assign jtag_ack        = r_jtag_ack;
  assign jtag_error      = r_jtag_error;
  assign wb_readData     = r_wb_readData;
  assign wb_ack          = r_wb_ack;
  assign wb_error        = r_wb_error;

endmodule

// File: tb/tb_management_bus_arbiter.sv
// Self-checking bench: directed scenarios then randomized transactions, each
// predicted from arbitration/latency rules rather than from the FSM.
module tb_management_bus_arbiter;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          jtag_enable = 1'b0, jtag_writeEnable = 1'b0;
  logic [3:0]    jtag_byteSelect = '0;
  logic [AW-1:0] jtag_address = '0;
  logic [DW-1:0] jtag_writeData = '0;
  logic [DW-1:0] jtag_readData;
  logic          jtag_ack, jtag_error;
  logic          wb_enable = 1'b0, wb_writeEnable = 1'b0;
  logic [3:0]    wb_byteSelect = '0;
  logic [AW-1:0] wb_address = '0;
  logic [DW-1:0] wb_writeData = '0;
  logic [DW-1:0] wb_readData;
  logic          wb_ack, wb_error, wb_busy;
  logic          bus_enable, bus_writeEnable;
  logic [3:0]    bus_byteSelect;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_writeData;
  logic [DW-1:0] bus_readData = '0;
  logic          bus_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  bit j_pend = 1'b0;     // requester still holding enable, waiting for service
  bit w_pend = 1'b0;
  bit m_last_wb = 1'b1;  // model: last grant went to Wishbone

  management_bus_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .jtag_enable(jtag_enable), .jtag_writeEnable(jtag_writeEnable),
    .jtag_byteSelect(jtag_byteSelect), .jtag_address(jtag_address),
    .jtag_writeData(jtag_writeData), .jtag_readData(jtag_readData),
    .jtag_ack(jtag_ack), .jtag_error(jtag_error),
    .wb_enable(wb_enable), .wb_writeEnable(wb_writeEnable),
    .wb_byteSelect(wb_byteSelect), .wb_address(wb_address),
    .wb_writeData(wb_writeData), .wb_readData(wb_readData),
    .wb_ack(wb_ack), .wb_error(wb_error), .wb_busy(wb_busy),
    .bus_enable(bus_enable), .bus_writeEnable(bus_writeEnable),
    .bus_byteSelect(bus_byteSelect), .bus_address(bus_address),
    .bus_writeData(bus_writeData), .bus_readData(bus_readData),
    .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_bus(input string ph, input logic en, input logic we,
                           input logic [3:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({ph, "_bus_enable"},      64'(bus_enable),      64'(en));
    check({ph, "_bus_writeEnable"}, 64'(bus_writeEnable), 64'(we));
    check({ph, "_bus_byteSelect"},  64'(bus_byteSelect),  64'(sel));
    check({ph, "_bus_address"},     64'(bus_address),     64'(a));
    check({ph, "_bus_writeData"},   64'(bus_writeData),   64'(d));
  endtask

  task automatic check_resp(input string ph, input logic ja, input logic je, input logic [DW-1:0] jr,
                            input logic wa, input logic we, input logic [DW-1:0] wr);
    check({ph, "_jtag_ack"},      64'(jtag_ack),      64'(ja));
    check({ph, "_jtag_error"},    64'(jtag_error),    64'(je));
    check({ph, "_jtag_readData"}, 64'(jtag_readData), 64'(jr));
    check({ph, "_wb_ack"},        64'(wb_ack),        64'(wa));
    check({ph, "_wb_error"},      64'(wb_error),      64'(we));
    check({ph, "_wb_readData"},   64'(wb_readData),   64'(wr));
  endtask

  task automatic scramble();
    jtag_writeEnable = 1'($urandom);
    jtag_byteSelect  = 4'($urandom);
    jtag_address     = AW'($urandom);
    jtag_writeData   = $urandom;
    wb_writeEnable   = 1'($urandom);
    wb_byteSelect    = 4'($urandom);
    wb_address       = AW'($urandom);
    wb_writeData     = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    jtag_enable = 1'b0;
    wb_enable = 1'b0;
    j_pend = 1'b0;
    w_pend = 1'b0;
    m_last_wb = 1'b1;
    #1;
    check_bus("reset", 1'b0, 1'b0, '0, '0, '0);
    check_resp("reset", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("reset_wb_busy", 64'(wb_busy), 64'(0));
    #1 rst = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    jtag_enable = 1'b0;
    wb_enable = 1'b0;
    bus_ready = 1'($urandom);
    bus_readData = $urandom;
    scramble();
    #1;
    check_bus("quiet", 1'b0, 1'b0, '0, '0, '0);
    check_resp("quiet", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("quiet_wb_busy", 64'(wb_busy), 64'(0));
  endtask

  // One arbitration round starting in an IDLE cycle. k = wait states before
  // bus_ready, abort_at = ACCESS cycle where the granted master drops enable
  // (0 = never), late_at = ACCESS/RESPOND cycle where the other master raises
  // enable (0 = never), rd = downstream read data offered with bus_ready.
  task automatic run_txn(input bit jreq, input bit wreq, input int k, input int abort_at,
                         input int late_at, input logic [DW-1:0] rd);
    bit jr, wr, gj, to, aborted;
    int comp, n, last;
    logic cw;
    logic [3:0] cs;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd, exp_rd, rsp;
    jr = jreq | j_pend;
    wr = wreq | w_pend;
    @(negedge clk);
    jtag_enable = jr;
    wb_enable = wr;
    bus_ready = 1'($urandom);
    bus_readData = $urandom;
    gj = jr && (!wr || m_last_wb);
    m_last_wb = !gj;
    if (gj) begin
      cw = jtag_writeEnable; cs = jtag_byteSelect; ca = jtag_address; cd = jtag_writeData;
    end else begin
      cw = wb_writeEnable; cs = wb_byteSelect; ca = wb_address; cd = wb_writeData;
    end
    #1;
    check_bus("idle", 1'b0, 1'b0, '0, '0, '0);
    check_resp("idle", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    // Completion in ACCESS cycle k+1, capped by the timeout at cycle T.
    to = (k + 1 > T);
    comp = to ? T : k + 1;
    aborted = (abort_at != 0) && (abort_at <= comp);
    n = aborted ? abort_at : comp;
    last = aborted ? n : n + 1;
    exp_rd = '0;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      if (i <= n) bus_ready = (i == k + 1);
      else        bus_ready = 1'($urandom);
      bus_readData = (i == k + 1) ? rd : $urandom;
      if (i == k + 1) exp_rd = rd;
      if (aborted && i == abort_at) begin
        if (gj) jtag_enable = 1'b0;
        else    wb_enable = 1'b0;
      end
      if (late_at == i) begin
        if (gj) wb_enable = 1'b1;
        else    jtag_enable = 1'b1;
      end
      scramble();
      #1;
      if (i <= n) begin
        check_bus("access", 1'b1, cw, cs, ca, cd);
        check_resp("access", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      end else begin
        rsp = to ? '1 : (cw ? '0 : exp_rd);
        check_bus("respond", 1'b0, 1'b0, '0, '0, '0);
        if (gj) check_resp("respond", 1'b1, to, rsp, 1'b0, 1'b0, '0);
        else    check_resp("respond", 1'b0, 1'b0, '0, 1'b1, to, rsp);
      end
      check("wb_busy", 64'(wb_busy), 64'(wb_enable && gj));
    end
    j_pend = gj ? 1'b0 : jtag_enable;
    w_pend = gj ? wb_enable : 1'b0;
  endtask

  initial begin
    #2;
    check_bus("por", 1'b0, 1'b0, '0, '0, '0);
    check_resp("por", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("por_wb_busy", 64'(wb_busy), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // JTAG read, zero wait states.
    jtag_writeEnable = 1'b0; jtag_byteSelect = 4'hF;
    jtag_address = 20'h10004; jtag_writeData = 32'h0;
    run_txn(1'b1, 1'b0, 0, 0, 0, 32'hDEADBEEF);

    // Both requesting from reset: JTAG, WB, JTAG, WB, 3 cycles apart.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      scramble();
      run_txn(1'b1, 1'b1, 0, 0, 0, $urandom);
    end

    // WB write with 3 wait states.
    do_reset();
    wb_writeEnable = 1'b1; wb_byteSelect = 4'hF;
    wb_address = 20'h00120; wb_writeData = 32'h12345678;
    run_txn(1'b0, 1'b1, 3, 0, 0, 32'hCAFEF00D);

    // WB read timing out with bus_ready held low.
    wb_writeEnable = 1'b0; wb_address = 20'h0ABCD;
    run_txn(1'b0, 1'b1, 100, 0, 0, '0);

    // Tie granted to JTAG, which aborts in its 2nd ACCESS cycle; WB next.
    scramble();
    run_txn(1'b1, 1'b1, 5, 2, 0, $urandom);
    scramble();
    run_txn(1'b0, 1'b0, 0, 0, 0, $urandom);

    // Asynchronous reset between edges in the middle of a JTAG access.
    scramble();
    @(negedge clk);
    jtag_enable = 1'b1; wb_enable = 1'b1; bus_ready = 1'b0;
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    check("pre_rst_bus_enable", 64'(bus_enable), 64'(1));
    check("pre_rst_wb_busy", 64'(wb_busy), 64'(1));
    #1 rst = 1'b1;
    #1;
    check_bus("mid_rst", 1'b0, 1'b0, '0, '0, '0);
    check_resp("mid_rst", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("mid_rst_wb_busy", 64'(wb_busy), 64'(0));
    jtag_enable = 1'b0; wb_enable = 1'b0;
    j_pend = 1'b0; w_pend = 1'b0; m_last_wb = 1'b1;
    #1 rst = 1'b0;
    scramble();
    run_txn(1'b1, 1'b1, 1, 0, 0, $urandom);

    // Randomized traffic: wait states across the timeout boundary, aborts, late requests.
    for (int t = 0; t < 150; t++) begin
      if (!j_pend && !w_pend && $urandom_range(0, 7) == 0) begin
        idle_cycle();
      end else begin
        int r;
        int ab;
        r = int'($urandom_range(1, 3));
        ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
        scramble();
        run_txn(r[0], r[1], int'($urandom_range(0, 6)), ab, int'($urandom_range(0, 7)), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/management_bus_arbiter.md
# management_bus_arbiter

Registered two-master arbiter that shares the core management bus between the JTAG debug port and the Wishbone slave port. It replaces fixed JTAG-over-Wishbone priority with round-robin grant and a request/acknowledge handshake. It also supports downstream wait states and enforces an access timeout. It sits between the JTAG/Wishbone management interfaces and the core management register/memory decode.

## Interface
- ADDRESS_WIDTH, 20, management address width
- DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 16, maximum cycles in ACCESS without `bus_ready` (legal range 1..255)

- clk  in  1  system clock
- rst  in  1  reset, asynchronous and active-high
- jtag_enable / wb_enable  in  1  request, held until ack
- jtag_writeEnable / wb_writeEnable  in  1  write when high, read when low
- jtag_byteSelect / wb_byteSelect  in  4  byte lanes
- jtag_address / wb_address  in  ADDRESS_WIDTH  target address
- jtag_writeData / wb_writeData  in  DATA_WIDTH  write data
- jtag_readData / wb_readData  out  DATA_WIDTH  registered read data, valid while ack is high
- jtag_ack / wb_ack  out  1  one-cycle completion strobe
- jtag_error / wb_error  out  1  qualifies ack; high when the access timed out
- wb_busy  out  1  `wb_enable` high and Wishbone not currently granted
- bus_enable  out  1  downstream access active
- bus_writeEnable  out  1  downstream write
- bus_byteSelect  out  4  downstream byte lanes
- bus_address  out  ADDRESS_WIDTH  downstream address
- bus_writeData  out  DATA_WIDTH  downstream write data
- bus_readData  in  DATA_WIDTH  downstream read data, sampled when `bus_ready` is high
- bus_ready  in  1  downstream completion, may be high in the first ACCESS cycle

## Operation
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE → ACCESS occurs when any enable is high.
  - Grant goes to the single requester, or on a tie to the requester not granted last.
  - The `lastGrant` register resets to WB, so JTAG wins the first tie.
  - The granted request's writeEnable, byteSelect, address and writeData are registered onto the bus_* outputs.
  - `lastGrant` is updated.
- ACCESS behaviour:
  - `bus_enable` is high and the bus_* outputs are held stable.
  - A timeout counter increments each cycle.
- ACCESS → RESPOND occurs on `bus_ready`.
  - For a read, `bus_readData` is registered into the granted readData.
  - For a write, the granted readData is 0.
  - error is 0.
- ACCESS → RESPOND also occurs on timeout: counter == TIMEOUT_CYCLES−1 with `bus_ready` low.
  - readData is all ones and error is 1.
- ACCESS → IDLE (abort) occurs when the granted enable drops before `bus_ready` or timeout.
  - No ack is issued.
  - A partial write side effect is the requester's problem.
- RESPOND → IDLE unconditionally.
  - The granted ack is high for exactly this cycle; error is valid with it.
  - Requesters drop enable on the clock edge where ack is sampled high, so the served master is not re-granted.
- In IDLE, RESPOND, and on abort, the bus_* outputs return to 0 (`bus_enable`=0, address/data/byteSelect = 0).
- The non-granted requester's ack, error and readData stay 0.
- Enables are sampled only in IDLE. A request arriving during ACCESS or RESPOND waits, and `wb_busy` reflects the wait.

## Timing
- Reset: state IDLE, `lastGrant`=WB, counter 0. Every output is 0, including both readData, ack, error, `wb_busy` and all bus_*.
- Minimum latency: enable high in cycle 0 → `bus_enable` cycle 1 → (`bus_ready` in cycle 1) ack cycle 2 → IDLE cycle 3.
- Throughput is at most one access per 3 cycles.
- With k wait states (`bus_ready` in ACCESS cycle k+1), ack arrives in cycle k+2.
- Timeout ack arrives in cycle TIMEOUT_CYCLES+1 after the request cycle.
- The downstream sees `bus_enable` for exactly TIMEOUT_CYCLES cycles on a timeout.
- `bus_ready` and timeout in the same cycle: `bus_ready` wins (normal completion, error 0).
- Abort and `bus_ready` in the same cycle: the abort wins.
- Reset asserted mid-access forces the reset state immediately (asynchronous). No ack is issued, and `bus_enable` drops without a clock edge.
- `wb_busy` is combinational from `wb_enable` and the state/grant; it is 0 in the cycle Wishbone's ack is high.

## Test plan
- JTAG read, addr 0x10004, `bus_ready` tied high, `bus_readData`=0xDEADBEEF → `bus_enable` cycle 1, `jtag_ack`=1 with `jtag_readData`=0xDEADBEEF in cycle 2, `jtag_error`=0, `wb_ack` never high.
- JTAG and WB both requesting from reset, back-to-back → grant order JTAG, WB, JTAG, WB; `wb_busy` high during JTAG service; accesses spaced 3 cycles with zero wait states.
- WB write 0x12345678, byteSelect 0xF, `bus_ready` after 3 wait states → bus_* stable for 4 cycles, `wb_ack` in cycle 5, `wb_readData`=0.
- TIMEOUT_CYCLES=4, `bus_ready` held low → `bus_enable` for 4 cycles, `wb_ack`=1 with `wb_error`=1 and `wb_readData`=0xFFFFFFFF.
- Granted JTAG drops enable in the 2nd ACCESS cycle → return to IDLE, `jtag_ack` never asserted, a pending WB request is granted next.
- `rst` pulsed mid-ACCESS between clock edges → `bus_enable` and all outputs 0 immediately; the first tie after release goes to JTAG.
